// File: rtl/button_encoder_pkg.sv
// Shared types and helpers for the button encoder: FSM state encoding,
// button count and index width, one-hot detect and index encode.
package button_encoder_pkg;

  localparam int unsigned NUM_BTN   = 4;
  localparam int unsigned BTN_IDX_W = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HELD  = 2'd1,
    S_CHORD = 2'd2
  } state_t;

  function automatic logic is_onehot(input logic [NUM_BTN-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic logic [BTN_IDX_W-1:0] btn_index(input logic [NUM_BTN-1:0] v);
    logic [BTN_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (v[i]) idx = BTN_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/button_encoder_if.sv
// Button event interface between the encoder (master) and the game FSM (slave).
interface button_encoder_if;
  import button_encoder_pkg::*;

  logic                 btn_valid;
  logic [BTN_IDX_W-1:0] btn_val;
  logic                 btn_held;
  logic                 chord_err;

  modport master (output btn_valid, output btn_val, output btn_held, output chord_err);
  modport slave  (input  btn_valid, input  btn_val, input  btn_held, input  chord_err);

endinterface

// File: rtl/button_encoder_btn_debounce.sv
// Single-button two-flop synchroniser followed by a mismatch-count debouncer.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic clk_tick,
  input  logic reset,
  input  logic raw,
  output logic deb
);

  localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_CYCLES - 1);

  logic       sync1;
  logic       sync2;
  logic [3:0] cnt;

  always_ff @(posedge clk_tick or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw ^ ACTIVE_LOW;
      sync2 <= sync1;
      // Flip only on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
      if (sync2 != deb) begin
        if (cnt == CNT_MAX) begin
          deb <= sync2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/button_encoder.sv
// Debounces four push-buttons and turns each clean single press into one
// btn_valid pulse with the button index; chords raise chord_err instead.
module button_encoder
  import button_encoder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic               clk_tick,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  button_encoder_if.master   bus,
  output logic [1:0]         state
);

  logic [NUM_BTN-1:0] deb;
  state_t             st;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_deb (
      .clk_tick (clk_tick),
      .reset    (reset),
      .raw      (btn_raw[i]),
      .deb      (deb[i])
    );
  end

  assign bus.btn_held = |deb;
  assign state        = st;

  always_ff @(posedge clk_tick or posedge reset) begin
    if (reset) begin
      st            <= S_IDLE;
      bus.btn_valid <= 1'b0;
      bus.btn_val   <= '0;
      bus.chord_err <= 1'b0;
    end else begin
      bus.btn_valid <= 1'b0;
      bus.chord_err <= 1'b0;
      case (st)
        S_IDLE: begin
          if (is_onehot(deb)) begin
            bus.btn_valid <= 1'b1;
            bus.btn_val   <= btn_index(deb);
            st            <= S_HELD;
          end else if (deb != '0) begin
            bus.chord_err <= 1'b1;
            st            <= S_CHORD;
          end
        end
        S_HELD, S_CHORD: begin
          // Only a full release re-arms; joins and partial releases are ignored.
          if (deb == '0) st <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_encoder.sv
// Scenario bench for button_encoder: a scoreboard of expected pulses is filled
// as buttons are driven and drained by a monitor watching btn_valid/chord_err.
module tb_button_encoder;

  localparam int DC  = 4;
  localparam int LAT = DC + 3;

  typedef struct {
    int         cyc;
    bit         chord;
    logic [1:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_raw = '0;
  logic [1:0] state;
  int         edge_cnt = 0;
  int         compared = 0;
  int         mismatched = 0;
  exp_t       exp_q[$];

  button_encoder_if bif ();

  button_encoder #(
    .DEBOUNCE_CYCLES (DC),
    .ACTIVE_LOW      (1'b0)
  ) dut (
    .clk_tick (clk),
    .reset    (rst),
    .btn_raw  (btn_raw),
    .bus      (bif),
    .state    (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bif.btn_valid || bif.chord_err)) begin
      if (bif.btn_valid && bif.chord_err) begin
        compared++; mismatched++;
        $display("FAIL both_pulses edge=%0d valid=%b chord=%b required not both", edge_cnt, bif.btn_valid, bif.chord_err);
      end
      if (exp_q.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_pulse edge=%0d valid=%b chord=%b val=%0d required none", edge_cnt, bif.btn_valid, bif.chord_err, bif.btn_val);
      end else begin
        e = exp_q.pop_front();
        compared++;
        if (edge_cnt !== e.cyc || bif.chord_err !== e.chord || bif.btn_val !== e.val) begin
          mismatched++;
          $display("FAIL pulse edge=%0d chord=%b val=%0d required edge=%0d chord=%b val=%0d", edge_cnt, bif.chord_err, bif.btn_val, e.cyc, e.chord, e.val);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc < edge_cnt) begin
      e = exp_q.pop_front();
      compared++; mismatched++;
      $display("FAIL missed_pulse edge=%0d required edge=%0d chord=%b val=%0d", edge_cnt, e.cyc, e.chord, e.val);
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    btn_raw = '0;
    repeat (3) @(negedge clk);
    compared += 5;
    if (bif.btn_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got=%b want=0", bif.btn_valid); end
    if (bif.btn_val !== 2'd0)   begin mismatched++; $display("FAIL reset_val got=%0d want=0", bif.btn_val); end
    if (bif.btn_held !== 1'b0)  begin mismatched++; $display("FAIL reset_held got=%b want=0", bif.btn_held); end
    if (bif.chord_err !== 1'b0) begin mismatched++; $display("FAIL reset_chord got=%b want=0", bif.chord_err); end
    if (state !== 2'd0)         begin mismatched++; $display("FAIL reset_state got=%0d want=0", state); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_press();
    int c;
    int n;
    btn_raw = 4'b0100;
    c = edge_cnt;
    exp_q.push_back('{c + LAT, 1'b0, 2'd2});
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      n = edge_cnt - c;
      compared += 2;
      if (bif.btn_held !== (n >= DC + 2)) begin
        mismatched++; $display("FAIL single_held n=%0d got=%b want=%b", n, bif.btn_held, n >= DC + 2);
      end
      if (state !== ((n >= LAT) ? 2'd1 : 2'd0)) begin
        mismatched++; $display("FAIL single_state n=%0d got=%0d want=%0d", n, state, (n >= LAT) ? 1 : 0);
      end
    end
    btn_raw = '0;
    repeat (10) @(negedge clk);
    compared += 2;
    if (state !== 2'd0)       begin mismatched++; $display("FAIL single_release_state got=%0d want=0", state); end
    if (bif.btn_val !== 2'd2) begin mismatched++; $display("FAIL single_val_stable got=%0d want=2", bif.btn_val); end
  endtask

  task automatic test_glitch();
    int c;
    btn_raw = 4'b0001;
    repeat (DC - 1) @(negedge clk);
    btn_raw = '0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      compared++;
      if (bif.btn_held !== 1'b0) begin mismatched++; $display("FAIL glitch_held k=%0d got=%b want=0", k, bif.btn_held); end
    end
    // A pulse exactly DEBOUNCE_CYCLES long is the shortest one that passes.
    btn_raw = 4'b0001;
    c = edge_cnt;
    exp_q.push_back('{c + LAT, 1'b0, 2'd0});
    repeat (DC) @(negedge clk);
    btn_raw = '0;
    repeat (20) @(negedge clk);
    compared++;
    if (state !== 2'd0) begin mismatched++; $display("FAIL glitch_min_state got=%0d want=0", state); end
  endtask

  task automatic test_back_to_back();
    int c;
    btn_raw = 4'b1000;
    c = edge_cnt;
    exp_q.push_back('{c + LAT, 1'b0, 2'd3});
    repeat (10) @(negedge clk);
    btn_raw = '0;
    repeat (10) @(negedge clk);
    compared++;
    if (state !== 2'd0) begin mismatched++; $display("FAIL b2b_gap_state got=%0d want=0", state); end
    btn_raw = 4'b0001;
    c = edge_cnt;
    exp_q.push_back('{c + LAT, 1'b0, 2'd0});
    repeat (10) @(negedge clk);
    compared++;
    if (bif.btn_val !== 2'd0) begin mismatched++; $display("FAIL b2b_val got=%0d want=0", bif.btn_val); end
    btn_raw = '0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_chord();
    int c;
    btn_raw = 4'b0110;
    c = edge_cnt;
    exp_q.push_back('{c + LAT, 1'b1, 2'd0});
    repeat (10) @(negedge clk);
    compared += 2;
    if (state !== 2'd2)       begin mismatched++; $display("FAIL chord_state got=%0d want=2", state); end
    if (bif.btn_val !== 2'd0) begin mismatched++; $display("FAIL chord_val got=%0d want=0", bif.btn_val); end
    btn_raw = '0;
    repeat (10) @(negedge clk);
    compared++;
    if (state !== 2'd0) begin mismatched++; $display("FAIL chord_release_state got=%0d want=0", state); end
    btn_raw = 4'b0010;
    c = edge_cnt;
    exp_q.push_back('{c + LAT, 1'b0, 2'd1});
    repeat (10) @(negedge clk);
    btn_raw = '0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_stagger();
    int c;
    btn_raw = 4'b0001;
    c = edge_cnt;
    exp_q.push_back('{c + LAT, 1'b0, 2'd0});
    repeat (2) @(negedge clk);
    btn_raw = 4'b0101;
    repeat (12) @(negedge clk);
    btn_raw = 4'b0100;
    repeat (12) @(negedge clk);
    compared += 3;
    if (state !== 2'd1)        begin mismatched++; $display("FAIL stagger_partial_state got=%0d want=1", state); end
    if (bif.btn_held !== 1'b1) begin mismatched++; $display("FAIL stagger_partial_held got=%b want=1", bif.btn_held); end
    if (bif.btn_val !== 2'd0)  begin mismatched++; $display("FAIL stagger_val got=%0d want=0", bif.btn_val); end
    btn_raw = '0;
    repeat (12) @(negedge clk);
    compared++;
    if (state !== 2'd0) begin mismatched++; $display("FAIL stagger_release_state got=%0d want=0", state); end
  endtask

  task automatic test_reset_mid_press();
    int c;
    btn_raw = 4'b0010;
    c = edge_cnt;
    exp_q.push_back('{c + LAT, 1'b0, 2'd1});
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    compared += 3;
    if (bif.btn_val !== 2'd0)  begin mismatched++; $display("FAIL midreset_val got=%0d want=0", bif.btn_val); end
    if (bif.btn_held !== 1'b0) begin mismatched++; $display("FAIL midreset_held got=%b want=0", bif.btn_held); end
    if (state !== 2'd0)        begin mismatched++; $display("FAIL midreset_state got=%0d want=0", state); end
    @(negedge clk);
    rst = 1'b0;
    c = edge_cnt;
    exp_q.push_back('{c + LAT, 1'b0, 2'd1});
    repeat (10) @(negedge clk);
    compared += 2;
    if (bif.btn_val !== 2'd1)  begin mismatched++; $display("FAIL midreset_repress_val got=%0d want=1", bif.btn_val); end
    if (bif.btn_held !== 1'b1) begin mismatched++; $display("FAIL midreset_repress_held got=%b want=1", bif.btn_held); end
    btn_raw = '0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_back_to_back();
    test_chord();
    test_stagger();
    test_reset_mid_press();
    repeat (5) @(negedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
